// File: rtl/ifu_pc_gen_pkg.sv
// Shared types and constants for the instruction-fetch PC generator.
// Optional BTB is enabled by defining IFU_BTB_EN.
package ifu_pc_gen_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [CPU_WIDTH-1:0] INST_ZERO = '0;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } ifu_state_t;

  // Static-prediction result for the word currently on the fetch bus
  typedef struct packed {
    logic                 taken;
    logic [CPU_WIDTH-1:0] target;
  } ifu_pred_t;

endpackage

// File: rtl/ifu_pc_gen_if.sv
// Fetch-stage bundle: hazard/redirect controls, imem port, IF/ID outputs, BTB update.
interface ifu_pc_gen_if;
  import ifu_pc_gen_pkg::*;

  logic                 stall;
  logic                 redirect;
  logic [CPU_WIDTH-1:0] redirect_pc;
  logic [CPU_WIDTH-1:0] imem_addr;
  logic [CPU_WIDTH-1:0] imem_inst;
  logic [CPU_WIDTH-1:0] inst;
  logic [CPU_WIDTH-1:0] curr_pc;
  logic [CPU_WIDTH-1:0] next_pc;
  logic                 control_hazard;
  logic                 fetch_valid;
  logic                 btb_upd_en;
  logic [CPU_WIDTH-1:0] btb_upd_pc;
  logic [CPU_WIDTH-1:0] btb_upd_target;

  // Pipeline/memory side
  modport master (
    output stall, redirect, redirect_pc, imem_inst,
    output btb_upd_en, btb_upd_pc, btb_upd_target,
    input  imem_addr, inst, curr_pc, next_pc, control_hazard, fetch_valid
  );

  // Fetch unit side
  modport slave (
    input  stall, redirect, redirect_pc, imem_inst,
    input  btb_upd_en, btb_upd_pc, btb_upd_target,
    output imem_addr, inst, curr_pc, next_pc, control_hazard, fetch_valid
  );

endinterface

// File: rtl/ifu_pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, posedge update.
// Instantiated by ifu_pc_gen only when IFU_BTB_EN is defined.
module ifu_pc_gen_btb
  import ifu_pc_gen_pkg::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] i_lookup_pc,
  output logic                 o_hit,
  output logic [CPU_WIDTH-1:0] o_target,
  input  logic                 i_upd_en,
  input  logic [CPU_WIDTH-1:0] i_upd_pc,
  input  logic [CPU_WIDTH-1:0] i_upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = CPU_WIDTH - 2 - IDX_W;

  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  logic [CPU_WIDTH-1:0] r_target [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_unused_low;

  assign w_lk_idx     = i_lookup_pc[2 +: IDX_W];
  assign w_lk_tag     = i_lookup_pc[CPU_WIDTH-1 -: TAG_W];
  assign w_up_idx     = i_upd_pc[2 +: IDX_W];
  assign w_up_tag     = i_upd_pc[CPU_WIDTH-1 -: TAG_W];
  assign w_unused_low = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  // Reads come from registered storage, so a same-cycle write is not visible yet
  assign o_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_target = r_target[w_lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_upd_en) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are qualified by r_valid
  always_ff @(posedge clk) begin
    if (i_upd_en) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= i_upd_target;
    end
  end

endmodule

// File: rtl/ifu_pc_gen.sv
// Instruction-fetch PC generator with static branch pre-decode.
// Define IFU_BTB_EN to add a direct-mapped BTB that overrides static prediction.
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned          BTB_ENTRIES = 4
) (
  input  logic         clk,
  input  logic         rst,
  ifu_pc_gen_if.slave  bus
);

  function automatic logic [CPU_WIDTH-1:0] imm_j(input logic [CPU_WIDTH-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [CPU_WIDTH-1:0] imm_b(input logic [CPU_WIDTH-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  ifu_state_t           r_state;
  logic [CPU_WIDTH-1:0] r_pc;

  logic                 w_run;
  logic [CPU_WIDTH-1:0] w_pc_plus4;
  logic [CPU_WIDTH-1:0] w_sum;
  ifu_pred_t            w_static;
  logic                 w_btb_hit;
  logic [CPU_WIDTH-1:0] w_btb_target;
  logic                 w_pred_taken;
  logic [CPU_WIDTH-1:0] w_pred_next;
  logic [CPU_WIDTH-1:0] w_next_pc;

  assign w_run      = (r_state == ST_RUN);
  assign w_pc_plus4 = r_pc + CPU_WIDTH'(4);

  // Static prediction: JAL always taken, conditional branch taken only when backward
  always_comb begin
    w_sum    = w_pc_plus4;
    w_static = '{taken: 1'b0, target: w_pc_plus4};
    case (bus.imem_inst[6:0])
      OPC_JAL: begin
        w_sum    = r_pc + imm_j(bus.imem_inst);
        w_static = '{taken: 1'b1, target: {w_sum[CPU_WIDTH-1:1], 1'b0}};
      end
      OPC_BRANCH: begin
        w_sum = r_pc + imm_b(bus.imem_inst);
        if (bus.imem_inst[31]) begin
          w_static = '{taken: 1'b1, target: {w_sum[CPU_WIDTH-1:1], 1'b0}};
        end
      end
      OPC_JALR: begin
        w_static = '{taken: 1'b0, target: w_pc_plus4};
      end
      default: begin
        w_static = '{taken: 1'b0, target: w_pc_plus4};
      end
    endcase
  end

`ifdef IFU_BTB_EN
  ifu_pc_gen_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_lookup_pc  (r_pc),
    .o_hit        (w_btb_hit),
    .o_target     (w_btb_target),
    .i_upd_en     (bus.btb_upd_en),
    .i_upd_pc     (bus.btb_upd_pc),
    .i_upd_target (bus.btb_upd_target)
  );
`else
  logic w_unused_btb;
  assign w_btb_hit    = 1'b0;
  assign w_btb_target = '0;
  assign w_unused_btb = ^{bus.btb_upd_en, bus.btb_upd_pc, bus.btb_upd_target,
                          CPU_WIDTH'(BTB_ENTRIES)};
`endif

  assign w_pred_taken = w_btb_hit | w_static.taken;
  assign w_pred_next  = w_btb_hit ? w_btb_target : w_static.target;
  assign w_next_pc    = w_run ? w_pred_next : RESET_PC;

  // Priority: rst > redirect > stall > predicted next PC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else if (bus.redirect) begin
      r_state <= ST_RUN;
      r_pc    <= bus.redirect_pc;
    end else if (!bus.stall) begin
      r_state <= ST_RUN;
      r_pc    <= w_next_pc;
    end
  end

  assign bus.imem_addr      = r_pc;
  assign bus.inst           = w_run ? bus.imem_inst : INST_ZERO;
  assign bus.curr_pc        = w_run ? r_pc : RESET_PC;
  assign bus.next_pc        = w_next_pc;
  assign bus.control_hazard = w_run & w_pred_taken;
  assign bus.fetch_valid    = w_run;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed self-checking bench for ifu_pc_gen; BTB steps run when IFU_BTB_EN is defined.
module tb_ifu_pc_gen;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JAL_P100 = 32'h1000_006F; // jal x0, +0x100
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] BEQ_P8   = 32'h0000_0463; // beq x0,x0,+8
  localparam logic [31:0] JALR_X1  = 32'h0000_8067; // jalr x0,0(x1)

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ifu_pc_gen_if u_if ();

  ifu_pc_gen #(
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] cpc, input logic [31:0] npc,
                         input logic hz, input logic vld);
    chk({tag, ".curr_pc"}, u_if.curr_pc, cpc);
    chk({tag, ".next_pc"}, u_if.next_pc, npc);
    chk({tag, ".hazard"}, 32'(u_if.control_hazard), 32'(hz));
    chk({tag, ".valid"}, 32'(u_if.fetch_valid), 32'(vld));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    u_if.stall          = 1'b0;
    u_if.redirect       = 1'b0;
    u_if.redirect_pc    = '0;
    u_if.imem_inst      = NOP;
    u_if.btb_upd_en     = 1'b0;
    u_if.btb_upd_pc     = '0;
    u_if.btb_upd_target = '0;

    // Reset for two cycles: BOOT outputs
    cyc();
    cyc();
    #1;
    chk_out("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst.inst", u_if.inst, 32'h0);
    rst = 1'b0;

    // One BOOT cycle after release, then sequential fetch
    #1;
    chk_out("boot", 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); #1;
    chk_out("seq0", 32'h0, 32'h4, 1'b0, 1'b1);
    chk("seq0.addr", u_if.imem_addr, 32'h0);
    chk("seq0.inst", u_if.inst, NOP);
    cyc(); #1;
    chk_out("seq4", 32'h4, 32'h8, 1'b0, 1'b1);
    cyc(); #1;
    chk_out("seq8", 32'h8, 32'hC, 1'b0, 1'b1);

    // JAL +0x100 at 0x40
    u_if.redirect = 1'b1; u_if.redirect_pc = 32'h40;
    cyc();
    u_if.redirect = 1'b0; u_if.imem_inst = JAL_P100; #1;
    chk_out("jal", 32'h40, 32'h140, 1'b1, 1'b1);
    chk("jal.inst", u_if.inst, JAL_P100);
    cyc();
    u_if.imem_inst = NOP; #1;
    chk_out("jal.tgt", 32'h140, 32'h144, 1'b0, 1'b1);

    // Backward branch taken, forward branch not taken, at 0x80
    u_if.redirect = 1'b1; u_if.redirect_pc = 32'h80;
    cyc();
    u_if.redirect = 1'b0; u_if.imem_inst = BEQ_M8; #1;
    chk_out("beq-8", 32'h80, 32'h78, 1'b1, 1'b1);
    u_if.imem_inst = BEQ_P8; #1;
    chk_out("beq+8", 32'h80, 32'h84, 1'b0, 1'b1);
    u_if.imem_inst = JALR_X1; #1;
    chk_out("jalr", 32'h80, 32'h84, 1'b0, 1'b1);
    u_if.imem_inst = NOP;

    // Stall three cycles at 0x10, then redirect wins over stall
    u_if.redirect = 1'b1; u_if.redirect_pc = 32'h10;
    cyc();
    u_if.redirect = 1'b0; u_if.stall = 1'b1; #1;
    chk_out("stall1", 32'h10, 32'h14, 1'b0, 1'b1);
    cyc(); #1;
    chk_out("stall2", 32'h10, 32'h14, 1'b0, 1'b1);
    cyc(); #1;
    chk_out("stall3", 32'h10, 32'h14, 1'b0, 1'b1);
    u_if.redirect = 1'b1; u_if.redirect_pc = 32'h200;
    cyc();
    u_if.redirect = 1'b0; u_if.stall = 1'b0; #1;
    chk_out("redir_stall", 32'h200, 32'h204, 1'b0, 1'b1);

    // Wrap at top of address space
    u_if.redirect = 1'b1; u_if.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    u_if.redirect = 1'b0; #1;
    chk_out("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
    cyc(); #1;
    chk_out("wrap.next", 32'h0, 32'h4, 1'b0, 1'b1);
    cyc(); #1;
    chk("pre_rst.pc", u_if.curr_pc, 32'h4);

    // Reset mid-run beats simultaneous redirect and stall
    rst = 1'b1; u_if.redirect = 1'b1; u_if.redirect_pc = 32'h300; u_if.stall = 1'b1;
    cyc(); #1;
    chk_out("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_mid.inst", u_if.inst, 32'h0);
    chk("rst_mid.addr", u_if.imem_addr, 32'h0);
    rst = 1'b0; u_if.stall = 1'b0; u_if.redirect_pc = 32'h600;

    // Redirect during BOOT goes straight to RUN at the target
    cyc();
    u_if.redirect = 1'b0; #1;
    chk_out("boot_redir", 32'h600, 32'h604, 1'b0, 1'b1);

`ifdef IFU_BTB_EN
    // Same-cycle update is not visible; next cycle the entry hits
    u_if.redirect = 1'b1; u_if.redirect_pc = 32'h30;
    cyc();
    u_if.redirect = 1'b0; u_if.stall = 1'b1; u_if.imem_inst = JALR_X1;
    u_if.btb_upd_en = 1'b1; u_if.btb_upd_pc = 32'h30; u_if.btb_upd_target = 32'h500; #1;
    chk_out("btb.old", 32'h30, 32'h34, 1'b0, 1'b1);
    cyc();
    u_if.btb_upd_en = 1'b0; #1;
    chk_out("btb.hit", 32'h30, 32'h500, 1'b1, 1'b1);
    // Same index, different tag: miss
    u_if.stall = 1'b0; u_if.redirect = 1'b1; u_if.redirect_pc = 32'h130;
    cyc();
    u_if.redirect = 1'b0; #1;
    chk_out("btb.alias", 32'h130, 32'h134, 1'b0, 1'b1);
    u_if.imem_inst = NOP;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
